decode_sequencer: RTL

//  Registered RV32I-subset decode stage: accepts 32-bit instructions from fetch over valid/ready,

---
 rtl/decode_pkg.sv | 52 +++++
 rtl/decode_comb.sv | 77 +++++++
 rtl/decode_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode constants, op indices, cycle counts, FSM states
// Purpose: opcode/funct3/funct7 encodings of the supported RV32I subset, one-hot
//          op bit positions, per-op execute cycle counts and sequencer state encoding.
// Ports:   none (package).
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // One-hot op bit positions: {JALR,BEQ,JAL,LUI,ADDI,LW,SW,SUB,ADD}
  localparam int OP_N    = 9;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SW   = 2;
  localparam int OP_LW   = 3;
  localparam int OP_ADDI = 4;
  localparam int OP_LUI  = 5;
  localparam int OP_JAL  = 6;
  localparam int OP_BEQ  = 7;
  localparam int OP_JALR = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Execute cycles per op; anything not listed (including no op) takes one.
  function automatic int unsigned op_cycles(input logic [OP_N-1:0] op);
    if (op[OP_LW])
      return 3;
    else if (op[OP_SW] | op[OP_BEQ] | op[OP_JAL] | op[OP_JALR])
      return 2;
    else
      return 1;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational op, register-field and immediate decode
// Purpose: classifies one instruction word into a one-hot op and extracts rs1/rs2/rd
//          and the format-specific immediate. No state.
// Ports:   instr (32) in; op (9) one-hot, legal, rs1/rs2/rd (5), imm (XLEN) out.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SEXT_MEM = 1'b1
) (
  input  logic [31:0]      instr,
  output logic [OP_N-1:0]  op,
  output logic             legal,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       fmt_r, fmt_i, fmt_sb, fmt_uj;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    op = '0;
    case (opcode)
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) op[OP_ADD] = 1'b1;
        if (funct3 == F3_ADD && funct7 == F7_SUB) op[OP_SUB] = 1'b1;
      end
      OPC_OPIMM:  op[OP_ADDI] = (funct3 == F3_ADD);
      OPC_LOAD:   op[OP_LW]   = (funct3 == F3_WORD);
      OPC_STORE:  op[OP_SW]   = (funct3 == F3_WORD);
      OPC_LUI:    op[OP_LUI]  = 1'b1;
      OPC_JAL:    op[OP_JAL]  = 1'b1;
      OPC_BRANCH: op[OP_BEQ]  = (funct3 == F3_BEQ);
      OPC_JALR:   op[OP_JALR] = (funct3 == F3_JALR);
      default:    op = '0;
    endcase
  end

  assign legal  = |op;
  assign fmt_r  = op[OP_ADD] | op[OP_SUB];
  assign fmt_i  = op[OP_ADDI] | op[OP_LW] | op[OP_JALR];
  assign fmt_sb = op[OP_SW] | op[OP_BEQ];
  assign fmt_uj = op[OP_LUI] | op[OP_JAL];

  // Fields the format does not carry read as x0 so execute never sees stray indices.
  assign rs1 = (fmt_r | fmt_i | fmt_sb) ? instr[19:15] : 5'd0;
  assign rs2 = (fmt_r | fmt_sb)         ? instr[24:20] : 5'd0;
  assign rd  = (fmt_r | fmt_i | fmt_uj) ? instr[11:7]  : 5'd0;

  always_comb begin
    imm = '0;
    if (op[OP_LW] | op[OP_JALR]) begin
      if (SEXT_MEM) imm = XLEN'($signed(instr[31:20]));
      else          imm = XLEN'(instr[31:20]);
    end else if (op[OP_SW]) begin
      if (SEXT_MEM) imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      else          imm = XLEN'({instr[31:25], instr[11:7]});
    end else if (op[OP_ADDI]) begin
      imm = XLEN'($signed(instr[31:20]));
    end else if (op[OP_LUI]) begin
      imm = XLEN'($signed({instr[31:12], 12'b0}));
    end else if (op[OP_JAL]) begin
      imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    end else if (op[OP_BEQ]) begin
      imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - registered decode stage with micro-step sequencer
// Purpose: accepts instructions over in_valid/in_ready, holds the decoded bundle and
//          steps out_step per out_ready handshake until the op's last step; illegal
//          words halt the stage until reset.
// Ports:   clk, rst; in_valid/in_ready/in_instr/in_pc; flush; out_valid/out_ready,
//          out_op/rs1/rs2/rd/imm/pc/step/last; halted, illegal_instr.
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 2,
  parameter bit SEXT_MEM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_N-1:0]   out_op,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [CNT_W-1:0]  out_step,
  output logic              out_last,
  output logic              halted,
  output logic [31:0]       illegal_instr
);

  logic [OP_N-1:0] dec_op;
  logic            dec_legal;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic [CNT_W-1:0] dec_last;

  decode_comb #(.XLEN(XLEN), .SEXT_MEM(SEXT_MEM)) u_decode_comb (
    .instr (in_instr),
    .op    (dec_op),
    .legal (dec_legal),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .rd    (dec_rd),
    .imm   (dec_imm)
  );

  // Index of the final micro-step for the word being offered.
  assign dec_last = CNT_W'(op_cycles(dec_op) - 1);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [OP_N-1:0]  op_q, op_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
  logic [CNT_W-1:0] step_q, step_d, last_q, last_d;
  logic             halted_q, halted_d;
  logic [31:0]      illegal_q, illegal_d;
  logic             at_last, ready_c, accept;

  assign at_last = valid_q & (step_q == last_q);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    step_d    = step_q;
    last_d    = last_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: ready_c = !flush;
      ST_BUSY: ready_c = at_last & out_ready & !flush;
      default: ready_c = 1'b0;
    endcase
    accept = in_valid & ready_c;

    if (state_q != ST_HALT) begin
      if (flush) begin
        // Squash wins over any pending handshake on either side.
        state_d = ST_IDLE;
        valid_d = 1'b0;
        step_d  = '0;
      end else if (accept) begin
        if (dec_legal) begin
          state_d = ST_BUSY;
          valid_d = 1'b1;
          op_d    = dec_op;
          rs1_d   = dec_rs1;
          rs2_d   = dec_rs2;
          rd_d    = dec_rd;
          imm_d   = dec_imm;
          pc_d    = in_pc;
          step_d  = '0;
          last_d  = dec_last;
        end else begin
          state_d   = ST_HALT;
          valid_d   = 1'b0;
          step_d    = '0;
          halted_d  = 1'b1;
          illegal_d = in_instr;
        end
      end else if (state_q == ST_BUSY && out_ready) begin
        if (!at_last) begin
          step_d = step_q + CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          step_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      step_q    <= '0;
      last_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      step_q    <= step_d;
      last_q    <= last_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready      = ready_c;
  assign out_valid     = valid_q;
  assign out_op        = op_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_rd        = rd_q;
  assign out_imm       = imm_q;
  assign out_pc        = pc_q;
  assign out_step      = step_q;
  assign out_last      = at_last;
  assign halted        = halted_q;
  assign illegal_instr = illegal_q;

endmodule
